// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store access controller.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_ACC = 2'd1,
    IO_ACC  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [31:0] IO_BASE_DEF  = 32'd1024;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sel;
  } req_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Routes one load/store per transaction to the sync data RAM (sel=0) or the handshaked IO bus (sel=1).
// Latency: store to RAM 2 cycles, RAM load RAM_LAT+1, IO access io_ready wait + 2 cycles.
// Backpressure: stall is high while RAM_ACC/IO_ACC; optional IO timeout under MEM_IO_TIMEOUT_EN.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int          RAM_AW  = 10,
  parameter int          RAM_LAT = 1,
  parameter logic [31:0] IO_BASE = IO_BASE_DEF,
  parameter int          IO_AW   = 4
`ifdef MEM_IO_TIMEOUT_EN
  ,
  parameter int          TIMEOUT = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              sel,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [IO_AW-1:0]  io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ready
`ifdef MEM_IO_TIMEOUT_EN
  ,
  output logic              io_err
`endif
);

  state_t      state, state_nxt;
  req_t        req_q;
  logic [1:0]  lat_cnt, lat_cnt_nxt;
  logic [31:0] rdata_q, rdata_nxt;
  logic        accept;
  logic        ram_act;
  logic        io_act;
`ifdef MEM_IO_TIMEOUT_EN
  logic [7:0]  to_cnt, to_cnt_nxt;
  logic        err_q, err_nxt;
`endif

  // A new request is taken whenever the controller is not busy, including the DONE cycle.
  assign accept = req_valid && ((state == IDLE) || (state == DONE));

  // Next-state and response-data selection.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    rdata_nxt   = rdata_q;
`ifdef MEM_IO_TIMEOUT_EN
    to_cnt_nxt  = to_cnt;
    err_nxt     = 1'b0;
`endif
    case (state)
      IDLE, DONE: begin
        if (req_valid) begin
          state_nxt   = sel ? IO_ACC : RAM_ACC;
          lat_cnt_nxt = 2'd0;
`ifdef MEM_IO_TIMEOUT_EN
          to_cnt_nxt  = 8'd0;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      RAM_ACC: begin
        if (req_q.we) begin
          state_nxt = DONE;
          rdata_nxt = 32'd0;
        end else if (lat_cnt == 2'(RAM_LAT - 1)) begin
          state_nxt = DONE;
          rdata_nxt = ram_rdata;
        end else begin
          lat_cnt_nxt = lat_cnt + 2'd1;
        end
      end
      IO_ACC: begin
        if (io_ready) begin
          state_nxt = DONE;
          rdata_nxt = req_q.we ? 32'd0 : io_rdata;
        end
`ifdef MEM_IO_TIMEOUT_EN
        else if (to_cnt == 8'(TIMEOUT - 1)) begin
          state_nxt = DONE;
          rdata_nxt = TIMEOUT_DATA;
          err_nxt   = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, captured request, counters and held response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_q   <= '0;
      lat_cnt <= 2'd0;
      rdata_q <= 32'd0;
`ifdef MEM_IO_TIMEOUT_EN
      to_cnt  <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      rdata_q <= rdata_nxt;
      if (accept) begin
        req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata, sel: sel};
      end
`ifdef MEM_IO_TIMEOUT_EN
      to_cnt  <= to_cnt_nxt;
      err_q   <= err_nxt;
`endif
    end
  end

  // The registered routing bit qualifies each bus so only the selected target is driven.
  assign ram_act = (state == RAM_ACC) && !req_q.sel;
  assign io_act  = (state == IO_ACC) && req_q.sel;

  assign stall     = (state == RAM_ACC) || (state == IO_ACC);
  assign rsp_valid = (state == DONE);
  assign rsp_rdata = rdata_q;

  assign ram_en    = ram_act && (lat_cnt == 2'd0);
  assign ram_we    = ram_act && req_q.we;
  assign ram_addr  = ram_act ? req_q.addr[RAM_AW-1:0] : '0;
  assign ram_wdata = ram_act ? req_q.wdata : 32'd0;

  // IO offset: full 32-bit subtraction, then truncation to the register offset width.
  assign io_req   = io_act;
  assign io_we    = io_act && req_q.we;
  assign io_addr  = io_act ? IO_AW'(req_q.addr - IO_BASE) : '0;
  assign io_wdata = io_act ? req_q.wdata : 32'd0;

`ifdef MEM_IO_TIMEOUT_EN
  assign io_err = (state == DONE) && err_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed literal cases, then a randomized run against a timeline model.
// Optional timeout behaviour is exercised when MEM_IO_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;

  localparam int          RAM_LAT = 1;
  localparam logic [31:0] IO_BASE = 32'd1024;
  localparam int          NC      = 1520;
  localparam int          NRAND   = 1500;

  logic        clk, rst_n;
  logic        req_valid, req_we, sel;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        io_req, io_we;
  logic [3:0]  io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic        io_ready;
`ifdef MEM_IO_TIMEOUT_EN
  logic        io_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  mem_access_ctrl #(
    .RAM_AW(10), .RAM_LAT(RAM_LAT), .IO_BASE(IO_BASE), .IO_AW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .sel(sel),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ready(io_ready)
`ifdef MEM_IO_TIMEOUT_EN
    , .io_err(io_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Timeline model: per-cycle expectations derived from the access latency rules.
  bit          model_en = 1'b0;
  int          rc = 0;
  bit          e_stall[NC], e_rsp[NC], e_ram_en[NC], e_ram_we[NC];
  bit          e_io_req[NC], e_io_we[NC], rdy_at[NC];
  logic [9:0]  e_ram_addr[NC];
  logic [3:0]  e_io_addr[NC];
  logic [31:0] e_ram_wdata[NC], e_io_wdata[NC], e_data[NC];
  int          cap_src[NC];
  logic [31:0] m_rdata = 32'd0;

  // Compare DUT outputs against the timeline model every cycle of the random run.
  always @(negedge clk) begin
    if (model_en) begin
      chk("r_stall", {31'd0, stall}, {31'd0, e_stall[rc]});
      chk("r_rsp_valid", {31'd0, rsp_valid}, {31'd0, e_rsp[rc]});
      chk("r_ram_en", {31'd0, ram_en}, {31'd0, e_ram_en[rc]});
      chk("r_io_req", {31'd0, io_req}, {31'd0, e_io_req[rc]});
      if (e_ram_en[rc]) begin
        chk("r_ram_addr", {22'd0, ram_addr}, {22'd0, e_ram_addr[rc]});
        chk("r_ram_we", {31'd0, ram_we}, {31'd0, e_ram_we[rc]});
        if (e_ram_we[rc]) chk("r_ram_wdata", ram_wdata, e_ram_wdata[rc]);
      end
      if (e_io_req[rc]) begin
        chk("r_io_addr", {28'd0, io_addr}, {28'd0, e_io_addr[rc]});
        chk("r_io_we", {31'd0, io_we}, {31'd0, e_io_we[rc]});
        if (e_io_we[rc]) chk("r_io_wdata", io_wdata, e_io_wdata[rc]);
      end
`ifdef MEM_IO_TIMEOUT_EN
      chk("r_io_err", {31'd0, io_err}, 32'd0);
`endif
      if (e_rsp[rc]) m_rdata = e_data[rc];
      chk("r_rsp_rdata", rsp_rdata, m_rdata);
    end
  end

  initial begin
    logic [31:0] off;
    int          n, w;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; sel = 1'b0;
    ram_rdata = '0; io_rdata = '0; io_ready = 1'b0;
    for (int i = 0; i < NC; i++) begin
      e_stall[i] = 0; e_rsp[i] = 0; e_ram_en[i] = 0; e_ram_we[i] = 0; e_io_req[i] = 0;
      e_io_we[i] = 0; rdy_at[i] = 0; e_ram_addr[i] = '0; e_io_addr[i] = '0;
      e_ram_wdata[i] = '0; e_io_wdata[i] = '0; e_data[i] = '0; cap_src[i] = 0;
    end

    // Reset state
    #12;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_io_req", {31'd0, io_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // RAM load from 100, RAM_LAT=1
    tick();
    req_valid = 1; req_we = 0; req_addr = 32'd100; req_wdata = $urandom; sel = 0;
    ram_rdata = 32'h1234_5678; io_ready = 1;
    @(negedge clk); chk("a_stall_c0", {31'd0, stall}, 32'd0);
    tick(); io_ready = 0;
    @(negedge clk);
    chk("a_stall_c1", {31'd0, stall}, 32'd1);
    chk("a_ram_en", {31'd0, ram_en}, 32'd1);
    chk("a_ram_addr", {22'd0, ram_addr}, 32'd100);
    chk("a_ram_we", {31'd0, ram_we}, 32'd0);
    chk("a_rsp_c1", {31'd0, rsp_valid}, 32'd0);
    tick(); req_valid = 0; ram_rdata = $urandom;
    @(negedge clk);
    chk("a_rsp_c2", {31'd0, rsp_valid}, 32'd1);
    chk("a_rdata", rsp_rdata, 32'h1234_5678);
    chk("a_stall_c2", {31'd0, stall}, 32'd0);
    tick();
    @(negedge clk);
    chk("a_rsp_c3", {31'd0, rsp_valid}, 32'd0);
    chk("a_rdata_hold", rsp_rdata, 32'h1234_5678);

    // IO store to 1028, io_ready in the third IO cycle
    tick();
    req_valid = 1; req_we = 1; req_addr = 32'd1028; req_wdata = 32'hA5A5_A5A5; sel = 1; io_ready = 0;
    for (int k = 1; k <= 3; k++) begin
      tick(); io_ready = (k == 3); io_rdata = $urandom;
      @(negedge clk);
      chk("b_io_req", {31'd0, io_req}, 32'd1);
      chk("b_io_addr", {28'd0, io_addr}, 32'd4);
      chk("b_io_we", {31'd0, io_we}, 32'd1);
      chk("b_io_wdata", io_wdata, 32'hA5A5_A5A5);
      chk("b_stall", {31'd0, stall}, 32'd1);
    end
    tick(); req_valid = 0; io_ready = 0;
    @(negedge clk);
    chk("b_io_req_drop", {31'd0, io_req}, 32'd0);
    chk("b_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("b_rdata", rsp_rdata, 32'd0);

    // Back-to-back: RAM store, then RAM load presented in the DONE cycle
    tick();
    req_valid = 1; req_we = 1; req_addr = 32'd8; req_wdata = 32'h1111_2222; sel = 0;
    tick();
    @(negedge clk);
    chk("c_ram_en", {31'd0, ram_en}, 32'd1);
    chk("c_ram_we", {31'd0, ram_we}, 32'd1);
    chk("c_ram_addr", {22'd0, ram_addr}, 32'd8);
    chk("c_ram_wdata", ram_wdata, 32'h1111_2222);
    tick(); req_we = 0; req_addr = 32'hFFFF_FC10;
    @(negedge clk);
    chk("c_rsp1", {31'd0, rsp_valid}, 32'd1);
    chk("c_stall_done", {31'd0, stall}, 32'd0);
    chk("c_rdata1", rsp_rdata, 32'd0);
    tick(); ram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("c_stall_ld", {31'd0, stall}, 32'd1);
    chk("c_ram_en_ld", {31'd0, ram_en}, 32'd1);
    chk("c_ram_addr_ld", {22'd0, ram_addr}, 32'd16);
    chk("c_ram_we_ld", {31'd0, ram_we}, 32'd0);
    chk("c_rsp_gap", {31'd0, rsp_valid}, 32'd0);
    tick(); req_valid = 0; ram_rdata = $urandom;
    @(negedge clk);
    chk("c_rsp2", {31'd0, rsp_valid}, 32'd1);
    chk("c_rdata2", rsp_rdata, 32'hCAFE_F00D);

    // IO load with io_ready in the first IO cycle
    tick();
    req_valid = 1; req_we = 0; req_addr = 32'd1031; sel = 1; io_ready = 0;
    tick(); io_ready = 1; io_rdata = 32'h0000_00FF;
    @(negedge clk);
    chk("d_io_req", {31'd0, io_req}, 32'd1);
    chk("d_io_addr", {28'd0, io_addr}, 32'd7);
    chk("d_io_we", {31'd0, io_we}, 32'd0);
    tick(); req_valid = 0; io_ready = 0; io_rdata = $urandom;
    @(negedge clk);
    chk("d_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("d_rdata", rsp_rdata, 32'h0000_00FF);
    chk("d_io_req_drop", {31'd0, io_req}, 32'd0);

`ifdef MEM_IO_TIMEOUT_EN
    // IO load that never sees io_ready
    tick();
    req_valid = 1; req_we = 0; req_addr = 32'd1044; sel = 1; io_ready = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      @(negedge clk);
      chk("t_io_req", {31'd0, io_req}, 32'd1);
      chk("t_io_err_low", {31'd0, io_err}, 32'd0);
    end
    tick(); req_valid = 0;
    @(negedge clk);
    chk("t_io_req_drop", {31'd0, io_req}, 32'd0);
    chk("t_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("t_io_err", {31'd0, io_err}, 32'd1);
    chk("t_rdata", rsp_rdata, 32'hDEAD_BEEF);
`endif

    // Reset while an IO access is outstanding
    tick();
    req_valid = 1; req_we = 0; req_addr = 32'd1030; sel = 1; io_ready = 0;
    tick();
    @(negedge clk);
    chk("e_io_req_pre", {31'd0, io_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("e_stall", {31'd0, stall}, 32'd0);
    chk("e_io_req", {31'd0, io_req}, 32'd0);
    chk("e_io_addr", {28'd0, io_addr}, 32'd0);
    chk("e_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("e_rdata", rsp_rdata, 32'd0);
    chk("e_ram_en", {31'd0, ram_en}, 32'd0);
    req_valid = 0; io_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("e_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("e_no_stall", {31'd0, stall}, 32'd0);
    end
    io_ready = 0;

    // Randomized run against the timeline model
    m_rdata = 32'd0;
    for (int i = 0; i < NRAND; i++) begin
      tick();
      rc = i;
      model_en = 1'b1;
      ram_rdata = $urandom;
      io_rdata  = $urandom;
      io_ready  = e_io_req[i] ? rdy_at[i] : 1'($urandom_range(0, 1));
      if (!e_stall[i]) begin
        if ($urandom_range(0, 3) != 0) begin
          req_valid = 1;
          req_we    = 1'($urandom_range(0, 1));
          sel       = 1'($urandom_range(0, 1));
          req_addr  = sel ? IO_BASE + 32'($urandom_range(0, 63)) : $urandom;
          req_wdata = $urandom;
          if (!sel) begin
            n = req_we ? 1 : RAM_LAT;
            e_ram_en[i+1]    = 1;
            e_ram_we[i+1]    = req_we;
            e_ram_addr[i+1]  = req_addr[9:0];
            e_ram_wdata[i+1] = req_wdata;
            if (!req_we) cap_src[i+n] = 1;
          end else begin
            w = $urandom_range(0, 4);
            n = w + 1;
            off = req_addr - IO_BASE;
            for (int k = 1; k <= n; k++) begin
              e_io_req[i+k]   = 1;
              e_io_we[i+k]    = req_we;
              e_io_addr[i+k]  = off[3:0];
              e_io_wdata[i+k] = req_wdata;
            end
            rdy_at[i+n] = 1;
            if (!req_we) cap_src[i+n] = 2;
          end
          for (int k = 1; k <= n; k++) e_stall[i+k] = 1;
          e_rsp[i+n+1] = 1;
          if (req_we) e_data[i+n+1] = 32'd0;
        end else begin
          req_valid = 0;
          req_we    = 1'($urandom_range(0, 1));
          sel       = 1'($urandom_range(0, 1));
          req_addr  = $urandom;
          req_wdata = $urandom;
        end
      end
      if (cap_src[i] == 1) e_data[i+1] = ram_rdata;
      if (cap_src[i] == 2) e_data[i+1] = io_rdata;
    end
    @(posedge clk);
    model_en = 1'b0;
    req_valid = 0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store access controller sitting directly downstream of the load address decoder (selection = 0: data RAM, addresses 0..1023; selection = 1: memory-mapped IO region, 1024 and up).
- Accepts one load/store request per transaction from the execute/memory stage.
- Uses the decoder's selection bit to route the access to the synchronous data RAM or to the handshaked IO bus.
- Stalls the pipeline until the access completes and returns load data with a one-cycle response strobe.

Parameters:
RAM_AW, 10, RAM address width; ram_addr = req_addr[RAM_AW-1:0]
RAM_LAT, 1, RAM read latency in cycles (1..3)
IO_BASE, 32'd1024, first IO byte address
IO_AW, 4, IO offset width; io_addr = (req_addr - IO_BASE)[IO_AW-1:0]
TIMEOUT, 16, IO wait limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  load/store request present
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data
sel  in  1  decoder selection for req_addr (0 = RAM, 1 = IO)
stall  out  1  hold pipeline; request inputs must stay stable while high
rsp_valid  out  1  one-cycle pulse: access finished
rsp_rdata  out  32  load data, valid with rsp_valid (0 for stores)
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  RAM_AW  RAM address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid RAM_LAT cycles after ram_en
io_req  out  1  IO request, held until io_ready
io_we  out  1  IO write
io_addr  out  IO_AW  IO register offset
io_wdata  out  32  IO write data
io_rdata  in  32  IO read data, valid when io_ready
io_ready  in  1  IO completes the access this cycle

Behaviour:
- Single clock. Reset is asynchronous and active-low (rst_n). Reset forces state IDLE and drives all outputs to 0, including the request registers and the latency counter.
- FSM states: IDLE, RAM_ACC, IO_ACC, DONE.
- Acceptance:
  - A request is accepted on a clock edge when the state is IDLE or DONE and req_valid = 1.
  - On acceptance, req_we, the address, req_wdata and sel are registered.
  - Next state is RAM_ACC if sel = 0, otherwise IO_ACC.
- stall = 1 exactly while the state is RAM_ACC or IO_ACC. stall is a registered-state decode and does not depend combinationally on req_valid.
- RAM_ACC:
  - ram_en = 1 in the first cycle only; ram_we = the registered req_we.
  - Store: one cycle, then DONE.
  - Load: a counter runs RAM_LAT cycles. In the last cycle, ram_rdata is captured into rsp_rdata, then the FSM goes to DONE.
  - Total latency from acceptance to rsp_valid: 2 cycles for a store, RAM_LAT+1 for a load.
- IO_ACC:
  - io_req stays 1 and io_addr/io_we/io_wdata stay stable until io_ready = 1.
  - In the io_ready cycle, io_rdata is captured (loads only), io_req drops on the next edge, and the FSM goes to DONE.
  - io_ready = 1 in the first IO_ACC cycle gives the minimum latency of 2 cycles.
  - io_ready while not in IO_ACC is ignored.
- DONE:
  - rsp_valid = 1 for exactly one cycle.
  - Without a new request, the FSM goes to IDLE. With req_valid = 1, the next request is accepted (back-to-back, no bubble).
- rsp_rdata holds its value until the next load completes; stores force it to 0.
- IO offset is computed with a 32-bit subtraction and then truncated to IO_AW bits.
- sel is trusted; req_addr bits above RAM_AW are ignored for RAM accesses.
- rst_n asserted mid-access: the access is abandoned immediately, and no rsp_valid is produced after release.

Optional Feature:
MEM_IO_TIMEOUT_EN
- Defined: an 8-bit counter runs in IO_ACC. After TIMEOUT cycles without io_ready:
  - io_req drops;
  - rsp_rdata = 32'hDEAD_BEEF;
  - an extra output io_err pulses together with rsp_valid in DONE.
  io_ready in the same cycle as the timeout wins (normal completion).
- Undefined: no counter and no io_err port; IO_ACC waits indefinitely.

Decomposition:
- Package mem_access_pkg: state enum (IDLE, RAM_ACC, IO_ACC, DONE), IO_BASE default, TIMEOUT_DATA = 32'hDEAD_BEEF, and a request struct {we, addr, wdata, sel}.
- No sub-module. The existing address decoder is instantiated beside the block, not inside it.

Test Plan:
- Reset mid-IO access (rst_n low while io_req = 1) -> all outputs 0 within the same cycle, state IDLE, no rsp_valid after release.
- Load addr 32'd100, sel = 0, RAM_LAT = 1, ram_rdata = 32'h1234_5678 -> ram_en/ram_addr = 100 in cycle 1, rsp_valid in cycle 2 with 32'h1234_5678, stall high for cycle 1 only.
- Store addr 32'd1028, data 32'hA5A5_A5A5, sel = 1, io_ready after 3 cycles -> io_req held 3 cycles with io_addr = 4, io_we = 1, then rsp_valid, rsp_rdata = 0.
- Back-to-back: RAM store accepted, then a RAM load presented during DONE -> load accepted in the DONE cycle with no IDLE bubble; two rsp_valid pulses 2 cycles apart.
- IO load with io_ready = 1 in the first IO_ACC cycle, io_rdata = 32'h0000_00FF -> rsp_valid 2 cycles after acceptance, rsp_rdata = 32'hFF.
- With MEM_IO_TIMEOUT_EN and TIMEOUT = 16, io_ready never asserted -> io_req drops after 16 cycles, then rsp_valid with io_err = 1 and rsp_rdata = 32'hDEAD_BEEF.
